updown_mod_counter: RTL and testbench

- Next-generation generic counter: parametrised width, runtime-programmable modulus, up/down direction, parallel load, wrap or saturate mode, built-in enable prescaler.
- Used for dice-face sequencing, display digit counters and slow timebases; TRIG_OUT cascades into the ENABLE of the next counter stage.

---
 rtl/updown_mod_counter.sv | 85 ++++++++
 tb/tb_updown_mod_counter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter: runtime modulus, parallel load, wrap or saturate at the
// limits, and an enable prescaler. TRIG_OUT can drive the ENABLE of the next stage.
module updown_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             UP_DOWN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  input  logic [WIDTH-1:0] MAX_VALUE,
  output logic [WIDTH-1:0] COUNT,
  output logic             TRIG_OUT,
  output logic             AT_LIMIT
);

  logic             step;
  logic [WIDTH-1:0] count_q, count_d;
  logic             trig_q, trig_d;

  generate
    if (PRESCALE <= 1) begin : g_no_prescale
      assign step = ENABLE;
    end else begin : g_prescale
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre_q;

      assign step = ENABLE && (pre_q == PRE_LAST);

      always_ff @(posedge CLK) begin
        if (RESET || LOAD) begin
          pre_q <= '0;
        end else if (ENABLE) begin
          pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    trig_d  = 1'b0;
    if (LOAD) begin
      count_d = (LOAD_VALUE > MAX_VALUE) ? MAX_VALUE : LOAD_VALUE;
    end else if (step) begin
      if (UP_DOWN) begin
        if (count_q >= MAX_VALUE) begin
          count_d = (SATURATE != 0) ? MAX_VALUE : '0;
          trig_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        // A count stranded above a lowered modulus snaps back without a pulse.
        if (count_q > MAX_VALUE) begin
          count_d = MAX_VALUE;
        end else if (count_q == '0) begin
          count_d = (SATURATE != 0) ? '0 : MAX_VALUE;
          trig_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
      trig_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      trig_q  <= trig_d;
    end
  end

  assign COUNT    = count_q;
  assign TRIG_OUT = trig_q;
  assign AT_LIMIT = UP_DOWN ? (count_q >= MAX_VALUE) : (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three instances (wrap, saturate, prescale-by-3)
// share one stimulus bus; each vector names which instance it checks.
module tb_updown_mod_counter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1, ENABLE = 1'b0, UP_DOWN = 1'b1, LOAD = 1'b0;
  logic [3:0] LOAD_VALUE = '0, MAX_VALUE = 4'd9;

  logic [3:0] cnt_w, cnt_s, cnt_p;
  logic       trg_w, trg_s, trg_p, lim_w, lim_s, lim_p;

  always #5 CLK = ~CLK;

  updown_mod_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(0)) dut_w (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .UP_DOWN(UP_DOWN), .LOAD(LOAD),
    .LOAD_VALUE(LOAD_VALUE), .MAX_VALUE(MAX_VALUE),
    .COUNT(cnt_w), .TRIG_OUT(trg_w), .AT_LIMIT(lim_w));

  updown_mod_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(1)) dut_s (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .UP_DOWN(UP_DOWN), .LOAD(LOAD),
    .LOAD_VALUE(LOAD_VALUE), .MAX_VALUE(MAX_VALUE),
    .COUNT(cnt_s), .TRIG_OUT(trg_s), .AT_LIMIT(lim_s));

  updown_mod_counter #(.WIDTH(4), .PRESCALE(3), .SATURATE(0)) dut_p (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .UP_DOWN(UP_DOWN), .LOAD(LOAD),
    .LOAD_VALUE(LOAD_VALUE), .MAX_VALUE(MAX_VALUE),
    .COUNT(cnt_p), .TRIG_OUT(trg_p), .AT_LIMIT(lim_p));

  typedef struct {
    int         sel;   // 0 = wrap, 1 = saturate, 2 = prescale 3
    logic       rst, en, ud, ld;
    logic [3:0] lv, mx;
    logic [3:0] ec;
    logic       et, ea;
  } vec_t;

  typedef struct {
    int         sel;
    logic [3:0] ec;
    logic       et, ea;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_vec = 0;

  task automatic add(input int sel, input logic rst, en, ud, ld,
                     input logic [3:0] lv, mx, ec, input logic et, ea);
    vec_t v;
    v.sel = sel; v.rst = rst; v.en = en; v.ud = ud; v.ld = ld;
    v.lv = lv; v.mx = mx; v.ec = ec; v.et = et; v.ea = ea;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got %0d expected %0d", nm, n_vec, act, exp);
    end
  endtask

  // Drive on the falling edge, push the expectation, compare just after the rising edge.
  task automatic apply(input vec_t v);
    exp_t e;
    logic [3:0] c;
    logic t, l;
    @(negedge CLK);
    RESET = v.rst; ENABLE = v.en; UP_DOWN = v.ud; LOAD = v.ld;
    LOAD_VALUE = v.lv; MAX_VALUE = v.mx;
    e.sel = v.sel; e.ec = v.ec; e.et = v.et; e.ea = v.ea;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    case (e.sel)
      1:       begin c = cnt_s; t = trg_s; l = lim_s; end
      2:       begin c = cnt_p; t = trg_p; l = lim_p; end
      default: begin c = cnt_w; t = trg_w; l = lim_w; end
    endcase
    $display("vec %0d dut %0d rst=%0b en=%0b ud=%0b ld=%0b lv=%0d mx=%0d -> count=%0d trig=%0b lim=%0b",
             n_vec, e.sel, v.rst, v.en, v.ud, v.ld, v.lv, v.mx, c, t, l);
    chk("count", c, e.ec);
    chk("trig", t, e.et);
    chk("at_limit", l, e.ea);
    n_vec++;
  endtask

  task automatic seq(input int sel, input logic rst, en, ud, ld,
                     input logic [3:0] lv, mx, ec, input logic et, ea);
    vec_t v;
    v.sel = sel; v.rst = rst; v.en = en; v.ud = ud; v.ld = ld;
    v.lv = lv; v.mx = mx; v.ec = ec; v.et = et; v.ea = ea;
    apply(v);
  endtask

  initial begin
    // Wrap, count up 0..9 for 12 steps
    add(0, 1, 0, 1, 0, 0, 9, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      add(0, 0, 1, 1, 0, 0, 9, 4'((i + 1) % 10), i == 9, ((i + 1) % 10) == 9);
    // ENABLE=0 right after a pulse clears TRIG_OUT and holds COUNT
    add(0, 0, 0, 1, 0, 0, 9, 2, 0, 0);
    // Wrap, count down from 0 with modulus 5
    add(0, 1, 0, 0, 0, 0, 5, 0, 0, 1);
    for (int i = 0; i < 7; i++)
      add(0, 0, 1, 0, 0, 0, 5, (i == 6) ? 4'd5 : 4'(5 - i), (i == 0) || (i == 6), i == 5);
    // Saturate, 10 up steps against modulus 6
    add(1, 1, 0, 1, 0, 0, 6, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add(1, 0, 1, 1, 0, 0, 6, (i < 6) ? 4'(i + 1) : 4'd6, i >= 6, i >= 5);
    // Saturate, down step at 0 holds and pulses
    add(1, 1, 0, 0, 0, 0, 6, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 6, 0, 1, 1);
    // MAX_VALUE=0: constant zero, pulse on every step
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 1, 1);
    // Runtime modulus drop: 8 with MAX 4, down -> 4 no pulse, up -> 0 with pulse
    add(0, 1, 0, 0, 0, 0, 9, 0, 0, 1);
    add(0, 0, 0, 0, 1, 8, 9, 8, 0, 0);
    add(0, 0, 1, 0, 0, 0, 4, 4, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4, 0, 1, 0);
    // Reset coinciding with a limit step drops the pulse
    add(0, 0, 0, 1, 1, 4, 4, 4, 0, 1);
    add(0, 1, 1, 1, 0, 0, 4, 0, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Prescale 3: ENABLE 1,1,0,1,1,1,1 steps on the 3rd and 6th enabled clocks
    seq(2, 1, 0, 1, 0, 0, 9, 0, 0, 0);
    seq(2, 0, 1, 1, 0, 0, 9, 0, 0, 0);
    seq(2, 0, 1, 1, 0, 0, 9, 0, 0, 0);
    seq(2, 0, 0, 1, 0, 0, 9, 0, 0, 0);
    seq(2, 0, 1, 1, 0, 0, 9, 1, 0, 0);
    seq(2, 0, 1, 1, 0, 0, 9, 1, 0, 0);
    seq(2, 0, 1, 1, 0, 0, 9, 1, 0, 0);
    seq(2, 0, 1, 1, 0, 0, 9, 2, 0, 0);
    // Load 12 clamps to 9 and swallows the coinciding step; prescaler restarts
    seq(2, 0, 1, 1, 0, 0, 9, 2, 0, 0);
    seq(2, 0, 1, 1, 0, 0, 9, 2, 0, 0);
    seq(2, 0, 1, 1, 1, 12, 9, 9, 0, 1);
    seq(2, 0, 1, 1, 0, 0, 9, 9, 0, 1);
    seq(2, 0, 1, 1, 0, 0, 9, 9, 0, 1);
    seq(2, 0, 1, 1, 0, 0, 9, 0, 1, 0);
    // LOAD together with RESET: reset wins
    seq(2, 0, 0, 1, 1, 7, 9, 7, 0, 0);
    seq(2, 1, 0, 1, 1, 5, 9, 0, 0, 0);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
